vending_controller: RTL and testbench

Parametrised keypad-driven vending controller. It consumes debounced, single-cycle key events from the keypad/debounce front end and performs the following functions:
- accumulates coin credit with saturation;
- vends selected items against per-item prices and stock counters;
- returns change as unit pulses;
- refunds on cancel or inactivity timeout.

Its credit and status outputs feed the existing binary2bcd/seven_segment display path.

---
 rtl/vending_controller.sv | 247 ++++++++++++++++++++++++
 tb/tb_vending_controller.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vending_controller.sv
// Keypad-driven vending controller: coin credit with saturation, priced and stocked
// item vends, change returned as unit pulses, refund on cancel or inactivity.
module vending_controller #(
    parameter int                            NUM_ITEMS   = 4,
    parameter int                            CREDIT_W    = 8,
    parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES      = {8'd75, 8'd50, 8'd40, 8'd25},
    parameter int                            COIN_A      = 5,
    parameter int                            COIN_B      = 10,
    parameter int                            COIN_C      = 25,
    parameter int                            MAX_CREDIT  = 200,
    parameter int                            CHANGE_UNIT = 5,
    parameter int                            STOCK_W     = 4,
    parameter int                            STOCK_INIT  = 3,
    parameter int                            TIMEOUT_CYC = 1000,
    parameter int                            DENY_CYC    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 key_valid,
    input  logic [3:0]           key_code,
    input  logic                 restock,
    output logic [CREDIT_W-1:0]  credit,
    output logic                 vend_pulse,
    output logic [3:0]           vend_item,
    output logic                 change_pulse,
    output logic                 coin_reject,
    output logic [NUM_ITEMS-1:0] sold_out,
    output logic [1:0]           status,
    output logic                 busy
);

    localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int DENY_W = $clog2(DENY_CYC + 1);

    localparam logic [CREDIT_W:0]   MAX_SUM   = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] UNIT      = CREDIT_W'(CHANGE_UNIT);
    localparam logic [TMO_W-1:0]    TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [DENY_W-1:0]   DENY_LAST = DENY_W'(DENY_CYC - 1);
    localparam logic [STOCK_W-1:0]  STOCK_RLD = STOCK_W'(STOCK_INIT);

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_NOCRED  = 2'd1;
    localparam logic [1:0] ST_SOLDOUT = 2'd2;
    localparam logic [1:0] ST_REFUND  = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        CREDIT,
        VEND,
        CHANGE,
        DENY
    } state_t;

    state_t                              state_q, state_n;
    logic [CREDIT_W-1:0]                 credit_q, credit_n;
    logic [NUM_ITEMS-1:0][STOCK_W-1:0]   stock_q, stock_n;
    logic [TMO_W-1:0]                    tmo_q, tmo_n;
    logic [DENY_W-1:0]                   deny_q, deny_n;
    logic [1:0]                          status_q, status_n;
    logic [3:0]                          vend_item_q, vend_item_n;
    logic                                vend_pulse_q, vend_pulse_n;
    logic                                change_pulse_q, change_pulse_n;
    logic                                coin_reject_q, coin_reject_n;
    logic                                busy_q, busy_n;

    logic                                is_coin;
    logic [CREDIT_W:0]                   coin_total;
    logic                                sel_hit;
    logic [CREDIT_W-1:0]                 sel_price;
    logic [STOCK_W-1:0]                  sel_stock;

    function automatic logic [CREDIT_W-1:0] coin_value(input logic [3:0] k);
        case (k)
            4'hA:    coin_value = CREDIT_W'(COIN_A);
            4'hB:    coin_value = CREDIT_W'(COIN_B);
            4'hC:    coin_value = CREDIT_W'(COIN_C);
            default: coin_value = '0;
        endcase
    endfunction

    // Sum is one bit wider than credit so a wrap can never masquerade as a fit.
    function automatic logic [CREDIT_W:0] coin_sum(input logic [CREDIT_W-1:0] a,
                                                   input logic [CREDIT_W-1:0] b);
        coin_sum = {1'b0, a} + {1'b0, b};
    endfunction

    function automatic logic coin_fits(input logic [CREDIT_W:0] s);
        coin_fits = (s <= MAX_SUM);
    endfunction

    always_comb begin
        is_coin    = (key_code == 4'hA) || (key_code == 4'hB) || (key_code == 4'hC);
        coin_total = coin_sum(credit_q, coin_value(key_code));
        sel_hit    = 1'b0;
        sel_price  = '0;
        sel_stock  = '0;
        for (int j = 0; j < NUM_ITEMS; j++) begin
            if (key_code == 4'(j)) begin
                sel_hit   = 1'b1;
                sel_price = PRICES[j*CREDIT_W +: CREDIT_W];
                sel_stock = stock_q[j];
            end
        end
    end

    always_comb begin
        state_n        = state_q;
        credit_n       = credit_q;
        stock_n        = stock_q;
        tmo_n          = tmo_q;
        deny_n         = deny_q;
        status_n       = status_q;
        vend_item_n    = vend_item_q;
        vend_pulse_n   = 1'b0;
        change_pulse_n = 1'b0;
        coin_reject_n  = 1'b0;

        case (state_q)
            IDLE: begin
                if (key_valid && is_coin) begin
                    credit_n = coin_value(key_code);
                    status_n = ST_OK;
                    tmo_n    = '0;
                    state_n  = CREDIT;
                end
            end
            CREDIT: begin
                if (key_valid && is_coin) begin
                    tmo_n = '0;
                    if (coin_fits(coin_total)) begin
                        credit_n = coin_total[CREDIT_W-1:0];
                        status_n = ST_OK;
                    end else begin
                        coin_reject_n = 1'b1;
                    end
                end else if (key_valid && sel_hit) begin
                    tmo_n = '0;
                    if (sel_stock == '0) begin
                        status_n = ST_SOLDOUT;
                        deny_n   = '0;
                        state_n  = DENY;
                    end else if (credit_q < sel_price) begin
                        status_n = ST_NOCRED;
                        deny_n   = '0;
                        state_n  = DENY;
                    end else begin
                        // The vend's effects land with the VEND state so pulse and credit agree.
                        vend_pulse_n = 1'b1;
                        vend_item_n  = key_code;
                        credit_n     = credit_q - sel_price;
                        status_n     = ST_OK;
                        for (int j = 0; j < NUM_ITEMS; j++) begin
                            if (key_code == 4'(j)) begin
                                stock_n[j] = stock_q[j] - STOCK_W'(1);
                            end
                        end
                        state_n = VEND;
                    end
                end else if (key_valid && (key_code == 4'hD)) begin
                    tmo_n    = '0;
                    status_n = ST_REFUND;
                    state_n  = CHANGE;
                end else if (tmo_q == TMO_LAST) begin
                    tmo_n    = '0;
                    status_n = ST_REFUND;
                    state_n  = CHANGE;
                end else begin
                    tmo_n = tmo_q + TMO_W'(1);
                end
            end
            VEND: begin
                state_n = (credit_q != '0) ? CHANGE : IDLE;
            end
            CHANGE: begin
                if (credit_q >= UNIT) begin
                    change_pulse_n = 1'b1;
                    credit_n       = credit_q - UNIT;
                end else begin
                    credit_n = '0;
                    state_n  = IDLE;
                end
            end
            DENY: begin
                if (deny_q == DENY_LAST) begin
                    deny_n  = '0;
                    tmo_n   = '0;
                    state_n = CREDIT;
                end else begin
                    deny_n = deny_q + DENY_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Restock overrides any same-cycle vend decrement.
        if (restock) begin
            stock_n = {NUM_ITEMS{STOCK_RLD}};
        end

        busy_n = (state_n == VEND) || (state_n == CHANGE) || (state_n == DENY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            credit_q       <= '0;
            stock_q        <= {NUM_ITEMS{STOCK_RLD}};
            tmo_q          <= '0;
            deny_q         <= '0;
            status_q       <= ST_OK;
            vend_item_q    <= '0;
            vend_pulse_q   <= 1'b0;
            change_pulse_q <= 1'b0;
            coin_reject_q  <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_n;
            credit_q       <= credit_n;
            stock_q        <= stock_n;
            tmo_q          <= tmo_n;
            deny_q         <= deny_n;
            status_q       <= status_n;
            vend_item_q    <= vend_item_n;
            vend_pulse_q   <= vend_pulse_n;
            change_pulse_q <= change_pulse_n;
            coin_reject_q  <= coin_reject_n;
            busy_q         <= busy_n;
        end
    end

    always_comb begin
        for (int j = 0; j < NUM_ITEMS; j++) begin
            sold_out[j] = (stock_q[j] == '0);
        end
    end

    assign credit       = credit_q;
    assign vend_pulse   = vend_pulse_q;
    assign vend_item    = vend_item_q;
    assign change_pulse = change_pulse_q;
    assign coin_reject  = coin_reject_q;
    assign status       = status_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_vending_controller.sv
// Bench for vending_controller: directed scenarios then random key traffic, checked
// against a transaction-level model of credit, stock and refund rules.
module tb_vending_controller;

    localparam int NUM_ITEMS   = 4;
    localparam int MAX_CREDIT  = 200;
    localparam int CHANGE_UNIT = 5;
    localparam int STOCK_INIT  = 3;
    localparam int TIMEOUT_CYC = 1000;
    localparam int DENY_CYC    = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_valid;
    logic [3:0] key_code;
    logic       restock;
    logic [7:0] credit;
    logic       vend_pulse;
    logic [3:0] vend_item;
    logic       change_pulse;
    logic       coin_reject;
    logic [3:0] sold_out;
    logic [1:0] status;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    int m_credit;
    int m_status;
    int m_stock[NUM_ITEMS];
    int price[NUM_ITEMS] = '{25, 40, 50, 75};

    vending_controller dut (
        .clk          (clk),
        .reset        (reset),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .restock      (restock),
        .credit       (credit),
        .vend_pulse   (vend_pulse),
        .vend_item    (vend_item),
        .change_pulse (change_pulse),
        .coin_reject  (coin_reject),
        .sold_out     (sold_out),
        .status       (status),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int coin_val(input logic [3:0] k);
        case (k)
            4'hA:    return 5;
            4'hB:    return 10;
            4'hC:    return 25;
            default: return 0;
        endcase
    endfunction

    function automatic logic [3:0] exp_sold();
        logic [3:0] r;
        r = '0;
        for (int j = 0; j < NUM_ITEMS; j++) r[j] = (m_stock[j] == 0);
        return r;
    endfunction

    task automatic model_restock();
        for (int j = 0; j < NUM_ITEMS; j++) m_stock[j] = STOCK_INIT;
    endtask

    task automatic press(input logic [3:0] k, input logic rs);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = k;
        restock   = rs;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'h0;
        restock   = 1'b0;
    endtask

    task automatic drain(input int exp_pulses, input string tag);
        int pulses;
        int cyc;
        pulses = 0;
        cyc    = 0;
        while (busy === 1'b1 && cyc < 600) begin
            if (change_pulse === 1'b1) pulses++;
            @(negedge clk);
            cyc++;
        end
        check({tag, "_bounded"}, (cyc < 600), 1);
        check({tag, "_pulses"}, pulses, exp_pulses);
        check({tag, "_credit0"}, credit, 0);
        m_credit = 0;
    endtask

    task automatic do_coin(input logic [3:0] k);
        int  v;
        logic rej;
        v   = coin_val(k);
        rej = 1'b0;
        if (m_credit == 0) begin
            m_credit = v;
            m_status = 0;
        end else if (m_credit + v <= MAX_CREDIT) begin
            m_credit = m_credit + v;
            m_status = 0;
        end else begin
            rej = 1'b1;
        end
        press(k, 1'b0);
        check("coin_credit", credit, m_credit);
        check("coin_reject", coin_reject, rej);
        check("coin_status", status, m_status);
        check("coin_busy", busy, 0);
    endtask

    task automatic do_select(input int i, input logic rs, input logic inject);
        int code;
        int cnt;
        if (m_credit == 0) begin
            press(4'(i), 1'b0);
            check("idle_sel_credit", credit, 0);
            check("idle_sel_busy", busy, 0);
            check("idle_sel_vend", vend_pulse, 0);
            return;
        end
        if (m_stock[i] == 0 || m_credit < price[i]) begin
            code = (m_stock[i] == 0) ? 2 : 1;
            press(4'(i), 1'b0);
            check("deny_busy", busy, 1);
            check("deny_status", status, code);
            check("deny_vend", vend_pulse, 0);
            cnt = 0;
            while (busy === 1'b1 && cnt < 50) begin
                if (inject && cnt == 2) begin
                    key_valid = 1'b1;
                    key_code  = 4'hC;
                end else begin
                    key_valid = 1'b0;
                end
                cnt++;
                @(negedge clk);
            end
            key_valid = 1'b0;
            check("deny_cycles", cnt, DENY_CYC);
            check("deny_credit", credit, m_credit);
            check("deny_status_hold", status, code);
            m_status = code;
        end else begin
            m_credit = m_credit - price[i];
            m_stock[i]--;
            if (rs) model_restock();
            m_status = 0;
            press(4'(i), rs);
            check("vend_pulse", vend_pulse, 1);
            check("vend_item", vend_item, i);
            check("vend_credit", credit, m_credit);
            check("vend_status", status, 0);
            drain(m_credit / CHANGE_UNIT, "vend_change");
            check("vend_sold_out", sold_out, exp_sold());
        end
    endtask

    task automatic do_cancel();
        if (m_credit == 0) begin
            press(4'hD, 1'b0);
            check("idle_cancel_busy", busy, 0);
            check("idle_cancel_credit", credit, 0);
            return;
        end
        press(4'hD, 1'b0);
        check("cancel_busy", busy, 1);
        check("cancel_status", status, 3);
        m_status = 3;
        drain(m_credit / CHANGE_UNIT, "cancel_change");
    endtask

    task automatic do_restock();
        @(negedge clk);
        restock = 1'b1;
        @(negedge clk);
        restock = 1'b0;
        model_restock();
        check("restock_sold_out", sold_out, exp_sold());
    endtask

    initial begin
        int n;
        int pulses;
        int r;
        logic [3:0] k;

        reset     = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'h0;
        restock   = 1'b0;
        m_credit  = 0;
        m_status  = 0;
        model_restock();
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("rst_credit", credit, 0);
        check("rst_vend_pulse", vend_pulse, 0);
        check("rst_vend_item", vend_item, 0);
        check("rst_change", change_pulse, 0);
        check("rst_reject", coin_reject, 0);
        check("rst_status", status, 0);
        check("rst_busy", busy, 0);
        check("rst_sold_out", sold_out, 0);

        do_coin(4'hA);
        do_coin(4'hB);
        do_coin(4'hC);
        do_select(1, 1'b0, 1'b0);

        repeat (3) do_coin(4'hC);
        do_select(0, 1'b0, 1'b0);

        do_coin(4'hB);
        do_select(3, 1'b0, 1'b1);
        do_coin(4'hA);
        do_cancel();

        repeat (3) begin
            do_coin(4'hC);
            do_coin(4'hC);
            do_select(2, 1'b0, 1'b0);
        end
        check("item2_sold_out", sold_out, 4'b0100);
        do_coin(4'hC);
        do_coin(4'hC);
        do_select(2, 1'b0, 1'b0);
        do_restock();
        do_cancel();

        repeat (8) do_coin(4'hC);
        do_coin(4'hA);
        n = 0;
        while (busy !== 1'b1 && n < 1100) begin
            @(negedge clk);
            n++;
        end
        check("timeout_cycles", n, TIMEOUT_CYC);
        check("timeout_status", status, 3);
        m_status = 3;
        drain(MAX_CREDIT / CHANGE_UNIT, "timeout_change");

        repeat (2) begin
            do_coin(4'hC);
            do_select(0, 1'b0, 1'b0);
        end
        do_coin(4'hC);
        do_select(0, 1'b1, 1'b0);

        do_coin(4'hC);
        do_coin(4'hC);
        do_select(1, 1'b0, 1'b0);
        press(4'hD, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_credit", credit, 0);
        check("midrst_busy", busy, 0);
        check("midrst_change", change_pulse, 0);
        check("midrst_status", status, 0);
        pulses = 0;
        repeat (6) begin
            if (change_pulse === 1'b1) pulses++;
            @(negedge clk);
        end
        check("midrst_no_pulses", pulses, 0);
        m_credit = 0;
        m_status = 0;
        model_restock();
        check("midrst_sold_out", sold_out, exp_sold());

        for (int it = 0; it < 200; it++) begin
            r = $urandom_range(0, 99);
            if (r < 45) begin
                k = 4'hA + 4'($urandom_range(0, 2));
                do_coin(k);
            end else if (r < 75) begin
                do_select($urandom_range(0, NUM_ITEMS - 1), 1'b0, 1'b0);
            end else if (r < 82) begin
                k = ($urandom_range(0, 1) == 0) ? 4'(4 + $urandom_range(0, 5))
                                                : 4'(14 + $urandom_range(0, 1));
                press(k, 1'b0);
                check("ignored_credit", credit, m_credit);
                check("ignored_busy", busy, 0);
            end else if (r < 88) begin
                do_cancel();
            end else if (r < 93) begin
                do_restock();
            end else begin
                repeat ($urandom_range(1, 4)) @(negedge clk);
                check("idle_credit", credit, m_credit);
            end
            check("rand_sold_out", sold_out, exp_sold());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
